ins_mem_loader: RTL and testbench

- Upstream program loader for the instruction RAM. It accepts a byte stream on a valid/ready interface, typically from the UART receiver.
- Stream framing: a length header, then the instruction words, then one checksum word.
- Writes the instruction words to consecutive RAM addresses starting at 0, reads them back through the RAM's registered-address read port, and reports done or error.
- While loading, the top level routes the RAM port to this block using mem_sel.

---
 rtl/ins_mem_loader_if.sv | 32 +++
 rtl/ins_mem_loader.sv | 154 +++++++++++++++
 tb/tb_ins_mem_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ins_mem_loader_if.sv
// Loader-side bus bundle: control/status, byte stream in, instruction RAM port out.
// The "master" side is the loader, which owns the RAM port while busy.
interface ins_mem_loader_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [WIDTH-1:0]      rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  mem_sel;
  logic                  mem_wrEn;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_dataIn;
  logic [WIDTH-1:0]      mem_dataOut;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH:0]   prog_len;

  modport master (
    input  start, rx_data, rx_valid, mem_dataOut,
    output rx_ready, mem_sel, mem_wrEn, mem_addr, mem_dataIn,
    output busy, done, error, prog_len
  );

  modport slave (
    output start, rx_data, rx_valid, mem_dataOut,
    input  rx_ready, mem_sel, mem_wrEn, mem_addr, mem_dataIn,
    input  busy, done, error, prog_len
  );
endinterface

// File: rtl/ins_mem_loader.sv
// Streams length/words/checksum into instruction RAM, then XOR-verifies by read-back (L+1 cycles).
// Backpressure: rx_ready follows state only; waits indefinitely for rx_valid in LEN/DATA/CSUM.
module ins_mem_loader #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  ins_mem_loader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_VERIFY
  } state_t;

  localparam logic [WIDTH:0]        DEPTH_W  = (WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ONE_L    = (ADDR_WIDTH+1)'(1);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] wcnt;
  logic [ADDR_WIDTH:0]   raddr;
  logic [ADDR_WIDTH:0]   prog_len;
  logic [WIDTH-1:0]      acc;
  logic [WIDTH-1:0]      exp_sum;
  logic                  done;
  logic                  error;

  logic                  beat;
  logic [WIDTH:0]        hdr_len;
  logic                  hdr_bad;
  logic                  last_word;
  logic                  last_read;
  logic                  sum_ok;

  logic                  rx_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;

  assign beat      = bus.rx_valid && rx_ready;
  // A zero header means a full-depth program.
  assign hdr_len   = (bus.rx_data == '0) ? DEPTH_W : {1'b0, bus.rx_data};
  assign hdr_bad   = (hdr_len > DEPTH_W);
  assign last_word = ({1'b0, wcnt} == (prog_len - ONE_L));
  assign last_read = (raddr == prog_len);
  assign sum_ok    = ((acc ^ bus.mem_dataOut) == exp_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_LEN;
      S_LEN:    if (beat) state_nxt = hdr_bad ? S_IDLE : S_DATA;
      S_DATA:   if (beat && last_word) state_nxt = S_CSUM;
      S_CSUM:   if (beat) state_nxt = S_VERIFY;
      S_VERIFY: if (last_read) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    wr_en    = 1'b0;
    addr     = '0;
    wdata    = '0;
    case (state)
      S_LEN, S_CSUM: rx_ready = 1'b1;
      S_DATA: begin
        rx_ready = 1'b1;
        wr_en    = bus.rx_valid;
        addr     = wcnt;
        wdata    = bus.rx_data;
      end
      S_VERIFY: addr = raddr[ADDR_WIDTH-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      raddr    <= '0;
      prog_len <= '0;
      acc      <= '0;
      exp_sum  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) error <= 1'b0;
        end
        S_LEN: begin
          if (beat) begin
            if (hdr_bad) begin
              error <= 1'b1;
            end else begin
              prog_len <= hdr_len[ADDR_WIDTH:0];
              wcnt     <= '0;
            end
          end
        end
        S_DATA: begin
          // Holding on the last word keeps a full-depth load from wrapping onto address 0.
          if (beat && !last_word) wcnt <= wcnt + ONE_A;
        end
        S_CSUM: begin
          if (beat) begin
            exp_sum <= bus.rx_data;
            acc     <= '0;
            raddr   <= '0;
          end
        end
        S_VERIFY: begin
          // Read data lags the address by one cycle, so the first cycle has nothing to fold in.
          if (raddr != '0) acc <= acc ^ bus.mem_dataOut;
          if (last_read) begin
            if (sum_ok) done  <= 1'b1;
            else        error <= 1'b1;
          end else begin
            raddr <= raddr + ONE_L;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.mem_wrEn   = wr_en;
  assign bus.mem_addr   = addr;
  assign bus.mem_dataIn = wdata;
  assign bus.busy       = (state != S_IDLE);
  assign bus.mem_sel    = (state != S_IDLE);
  assign bus.done       = done;
  assign bus.error      = error;
  assign bus.prog_len   = prog_len;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader: vector table of full loads plus reset/abort and bad-header sequences.
module tb_ins_mem_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ins_mem_loader_if #(.WIDTH(8), .ADDR_WIDTH(8)) ifc1 ();
  ins_mem_loader_if #(.WIDTH(8), .ADDR_WIDTH(4)) ifc2 ();

  ins_mem_loader #(.WIDTH(8), .DEPTH(256), .ADDR_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .bus(ifc1.master));
  ins_mem_loader #(.WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst), .bus(ifc2.master));

  // RAM models with registered read address
  logic [7:0] ram1 [256];
  logic [7:0] ra1_q;
  always @(posedge clk) begin
    if (ifc1.mem_wrEn) ram1[ifc1.mem_addr] <= ifc1.mem_dataIn;
    ra1_q <= ifc1.mem_addr;
  end
  assign ifc1.mem_dataOut = ram1[ra1_q];

  logic [7:0] ram2 [16];
  logic [3:0] ra2_q;
  int wr2_cnt = 0;
  always @(posedge clk) begin
    if (ifc2.mem_wrEn) begin
      ram2[ifc2.mem_addr] <= ifc2.mem_dataIn;
      wr2_cnt <= wr2_cnt + 1;
    end
    ra2_q <= ifc2.mem_addr;
  end
  assign ifc2.mem_dataOut = ram2[ra2_q];

  typedef struct {
    logic [7:0]      hdr;
    logic [3:0][7:0] words;
    logic [7:0]      csum;
    bit              gap;
    bit              exp_done;
    bit              exp_err;
    int              exp_len;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int failures = 0;
  int vcyc, done_cnt, bad_wr;
  int wr_cnt [256];
  logic last_beat, s_busy, s_done, s_error;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sample on the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    last_beat = ifc1.rx_valid && ifc1.rx_ready;
    s_busy    = ifc1.busy;
    s_done    = ifc1.done;
    s_error   = ifc1.error;
    if (s_busy && !ifc1.rx_ready) vcyc++;
    if (s_done) done_cnt++;
    if (ifc1.mem_wrEn) begin
      if (!last_beat) bad_wr++;
      wr_cnt[ifc1.mem_addr]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input bit gap);
    int guard = 0;
    do begin
      ifc1.rx_data  = w;
      ifc1.rx_valid = gap ? ($urandom_range(0, 1) == 1) : 1'b1;
      tick();
      guard++;
    end while (!last_beat && guard < 200);
    ifc1.rx_valid = 1'b0;
    if (!last_beat) chk("beat_timeout", 0, 1);
  endtask

  function automatic logic [7:0] word_of(input vec_t v, input int i);
    return (v.hdr == 8'h00) ? 8'(i) : v.words[i];
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int n, guard, errs;
    bit seen;
    n = (v.hdr == 8'h00) ? 256 : int'(v.hdr);
    vcyc = 0; done_cnt = 0; bad_wr = 0;
    for (int i = 0; i < 256; i++) wr_cnt[i] = 0;
    ifc1.start = 1'b1;
    tick();
    ifc1.start = 1'b0;
    chk($sformatf("v%0d_busy_after_start", idx), ifc1.busy, 1);
    chk($sformatf("v%0d_err_cleared", idx), ifc1.error, 0);
    send(v.hdr, v.gap);
    for (int i = 0; i < n; i++) send(word_of(v, i), v.gap);
    send(v.csum, v.gap);
    seen = 0;
    guard = 0;
    while (!seen && guard < n + 20) begin
      tick();
      guard++;
      if (s_done || s_error) seen = 1;
    end
    chk($sformatf("v%0d_finished", idx), seen, 1);
    chk($sformatf("v%0d_busy_at_result", idx), s_busy, 0);
    repeat (3) tick();
    chk($sformatf("v%0d_done_pulses", idx), done_cnt, v.exp_done);
    chk($sformatf("v%0d_error", idx), ifc1.error, v.exp_err);
    chk($sformatf("v%0d_prog_len", idx), ifc1.prog_len, v.exp_len);
    chk($sformatf("v%0d_verify_cycles", idx), vcyc, n + 1);
    chk($sformatf("v%0d_busy_after", idx), ifc1.busy, 0);
    chk($sformatf("v%0d_wr_without_beat", idx), bad_wr, 0);
    errs = 0;
    for (int i = 0; i < n; i++) if (ram1[i] !== word_of(v, i)) errs++;
    chk($sformatf("v%0d_ram_mismatches", idx), errs, 0);
    errs = 0;
    for (int i = 0; i < 256; i++) if (wr_cnt[i] != ((i < n) ? 1 : 0)) errs++;
    chk($sformatf("v%0d_write_counts", idx), errs, 0);
  endtask

  initial begin
    vecs[0] = '{8'h03, {8'h00, 8'h44, 8'h22, 8'h11}, 8'h77, 1'b0, 1'b1, 1'b0, 3};
    vecs[1] = '{8'h03, {8'h00, 8'h44, 8'h22, 8'h11}, 8'h76, 1'b0, 1'b0, 1'b1, 3};
    vecs[2] = '{8'h00, {8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 1'b0, 1'b1, 1'b0, 256};
    vecs[3] = '{8'h03, {8'h00, 8'h44, 8'h22, 8'h11}, 8'h77, 1'b1, 1'b1, 1'b0, 3};
    vecs[4] = '{8'h01, {8'h00, 8'h00, 8'h00, 8'hA5}, 8'hA5, 1'b0, 1'b1, 1'b0, 1};
    vecs[5] = '{8'h02, {8'h00, 8'h00, 8'h0F, 8'h5A}, 8'h55, 1'b0, 1'b1, 1'b0, 2};

    ifc1.start = 1'b0; ifc1.rx_valid = 1'b0; ifc1.rx_data = 8'h00;
    ifc2.start = 1'b0; ifc2.rx_valid = 1'b0; ifc2.rx_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_busy", ifc1.busy, 0);
    chk("rst_mem_sel", ifc1.mem_sel, 0);
    chk("rst_rx_ready", ifc1.rx_ready, 0);
    chk("rst_mem_wrEn", ifc1.mem_wrEn, 0);
    chk("rst_mem_addr", ifc1.mem_addr, 0);
    chk("rst_done", ifc1.done, 0);
    chk("rst_error", ifc1.error, 0);
    chk("rst_prog_len", ifc1.prog_len, 0);
    chk("rst2_busy", ifc2.busy, 0);

    ifc1.rx_valid = 1'b1;
    tick();
    ifc1.rx_valid = 1'b0;
    chk("idle_no_beat", last_beat, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Start during DATA is ignored, then reset aborts mid-load.
    ifc1.start = 1'b1;
    tick();
    ifc1.start = 1'b0;
    send(8'h03, 1'b0);
    send(8'hC1, 1'b0);
    ifc1.start = 1'b1;
    tick();
    ifc1.start = 1'b0;
    chk("abort_start_ignored_ready", ifc1.rx_ready, 1);
    chk("abort_start_ignored_busy", ifc1.busy, 1);
    send(8'hC2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc1.rx_valid = 1'b1;
    ifc1.rx_data  = 8'hEE;
    #1;
    chk("abort_busy", ifc1.busy, 0);
    chk("abort_mem_sel", ifc1.mem_sel, 0);
    chk("abort_mem_wrEn", ifc1.mem_wrEn, 0);
    chk("abort_rx_ready", ifc1.rx_ready, 0);
    chk("abort_prog_len", ifc1.prog_len, 0);
    tick();
    ifc1.rx_valid = 1'b0;
    chk("abort_ram0", ram1[0], 8'hC1);
    chk("abort_ram1", ram1[1], 8'hC2);
    chk("abort_ram2", ram1[2], 8'h44);

    // Oversized header on the 16-deep instance, then recovery.
    ifc2.start = 1'b1;
    @(posedge clk); #1;
    ifc2.start = 1'b0;
    chk("bad_hdr_busy_before", ifc2.busy, 1);
    ifc2.rx_data  = 8'h20;
    ifc2.rx_valid = 1'b1;
    @(posedge clk); #1;
    ifc2.rx_valid = 1'b0;
    chk("bad_hdr_error", ifc2.error, 1);
    chk("bad_hdr_busy", ifc2.busy, 0);
    chk("bad_hdr_mem_sel", ifc2.mem_sel, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bad_hdr_error_sticky", ifc2.error, 1);
    chk("bad_hdr_no_writes", wr2_cnt, 0);
    ifc2.start = 1'b1;
    @(posedge clk); #1;
    ifc2.start = 1'b0;
    chk("restart_error_cleared", ifc2.error, 0);
    chk("restart_busy", ifc2.busy, 1);
    ifc2.rx_data  = 8'h10;
    ifc2.rx_valid = 1'b1;
    @(posedge clk); #1;
    ifc2.rx_valid = 1'b0;
    chk("full_hdr_error", ifc2.error, 0);
    chk("full_hdr_prog_len", ifc2.prog_len, 16);
    chk("full_hdr_busy", ifc2.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("final_rst_busy", ifc2.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
